// File: rtl/ahbl_apb_bridge_gen2.sv
// AHB-Lite to APB bridge: one APB transfer per AHB transfer, slot-decoded PSEL,
// two-cycle AHB error response for bad slots, PSLVERR and APB wait timeouts.
module ahbl_apb_bridge_gen2 #(
    parameter int NUM_SLAVES = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int SEL_LSB    = 24,
    parameter int TIMEOUT    = 256
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [1:0]            HTRANS,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADYIN,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,
    output logic [NUM_SLAVES-1:0] PSEL,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic                  PENABLE,
    output logic [31:0]           PWDATA,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2} state_t;

    state_t                  state_q;
    logic [NUM_SLAVES-1:0]   psel_q;
    logic                    penable_q;
    logic                    pwrite_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [31:0]             pwdata_q;
    logic [31:0]             hrdata_q;
    logic                    hresp_q;
    logic                    hreadyout_q;
    logic [CNT_W-1:0]        wait_q;
    logic [CNT_W-1:0]        wait_d;

    logic                    accept;
    logic [3:0]              slot;
    logic                    slot_bad;
    logic [NUM_SLAVES-1:0]   slot_dec;
    logic                    timeout_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign accept      = HSEL && HREADYIN && (HTRANS == 2'b10 || HTRANS == 2'b11);
    assign slot        = paddr_q[SEL_LSB+3:SEL_LSB];
    assign slot_bad    = {1'b0, slot} >= 5'(NUM_SLAVES);
    assign wait_d      = sat_inc(wait_q);
    assign timeout_hit = (TIMEOUT != 0) && (32'(wait_d) >= 32'(TIMEOUT));

    always_comb begin
        slot_dec = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            slot_dec[i] = (slot == 4'(i));
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            hrdata_q    <= '0;
            hresp_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            wait_q      <= '0;
        end else begin
            case (state_q)
                IDLE, ERR2: begin
                    hresp_q <= 1'b0;
                    if (accept) begin
                        paddr_q     <= HADDR;
                        pwrite_q    <= HWRITE;
                        hreadyout_q <= 1'b0;
                        state_q     <= LATCH;
                    end else begin
                        hreadyout_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                LATCH: begin
                    if (pwrite_q) pwdata_q <= HWDATA;
                    // Out-of-range slots never touch the APB side.
                    if (slot_bad) begin
                        hresp_q <= 1'b1;
                        state_q <= ERR1;
                    end else begin
                        psel_q  <= slot_dec;
                        wait_q  <= '0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY is checked first so completion beats a coinciding timeout.
                    if (PREADY) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        if (PSLVERR) begin
                            hresp_q <= 1'b1;
                            state_q <= ERR1;
                        end else begin
                            if (!pwrite_q) hrdata_q <= PRDATA;
                            hreadyout_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end else begin
                        wait_q <= wait_d;
                        if (timeout_hit) begin
                            psel_q    <= '0;
                            penable_q <= 1'b0;
                            hresp_q   <= 1'b1;
                            state_q   <= ERR1;
                        end
                    end
                end
                ERR1: begin
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                    state_q     <= ERR2;
                end
                default: begin
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRDATA    = hrdata_q;
    assign HRESP     = hresp_q;
    assign PSEL      = psel_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PENABLE   = penable_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahbl_apb_bridge_gen2.sv
// Directed bench for ahbl_apb_bridge_gen2 with four APB slots and an 8-cycle timeout.
module tb_ahbl_apb_bridge_gen2;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HREADYIN;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic [3:0]  PSEL;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_chk  = 0;
    int n_pass = 0;

    // Per-transfer observations filled in by xfer.
    int          lowcyc, acccyc, onehot_viol;
    logic [3:0]  psel_seen;
    logic [31:0] paddr_seen, pwdata_seen;
    logic        pwrite_seen, resp_low_last, done_ok;

    ahbl_apb_bridge_gen2 #(
        .NUM_SLAVES(4), .ADDR_WIDTH(32), .SEL_LSB(24), .TIMEOUT(8)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HWDATA(HWDATA), .HREADYIN(HREADYIN), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HRESP(HRESP), .PSEL(PSEL), .PADDR(PADDR), .PWRITE(PWRITE),
        .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Presents an address phase in the current cycle and runs until HREADYOUT returns high.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int nwait, input logic slverr, input logic [31:0] rdata);
        HSEL = 1'b1; HADDR = addr; HWRITE = wr; HTRANS = 2'b10; HREADYIN = 1'b1;
        PRDATA = rdata; PREADY = 1'b0; PSLVERR = 1'b0;
        lowcyc = 0; acccyc = 0; onehot_viol = 0; psel_seen = '0;
        paddr_seen = '0; pwdata_seen = '0; pwrite_seen = 1'b0; resp_low_last = 1'b0;
        done_ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
            if ($countones(PSEL) > 1) onehot_viol++;
            psel_seen |= PSEL;
            if (HREADYOUT) begin
                done_ok = 1'b1;
                break;
            end
            lowcyc++;
            resp_low_last = HRESP;
            if (PENABLE) begin
                acccyc++;
                paddr_seen = PADDR; pwdata_seen = PWDATA; pwrite_seen = PWRITE;
                PREADY  = (acccyc > nwait);
                PSLVERR = slverr && PREADY;
            end else begin
                PREADY = 1'b0; PSLVERR = 1'b0;
            end
        end
        PREADY = 1'b0; PSLVERR = 1'b0;
        check("xfer_done", 32'(done_ok), 32'd1);
        check("psel_onehot_viol", 32'(onehot_viol), 32'd0);
    endtask

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HTRANS = 2'b00;
        HWDATA = '0; HREADYIN = 1'b1; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        repeat (3) tick();
        check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst_hresp", 32'(HRESP), 32'd0);
        check("rst_psel", 32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_paddr", PADDR, 32'd0);
        check("rst_pwdata", PWDATA, 32'd0);
        check("rst_hrdata", HRDATA, 32'd0);
        HRESET = 1'b0;

        // Zero-wait write to slot 3, accepted on the first edge after reset release.
        xfer(1'b1, 32'h0300_0010, 32'hA5A5_0001, 0, 1'b0, 32'h0);
        check("wr_low", 32'(lowcyc), 32'd3);
        check("wr_acc", 32'(acccyc), 32'd1);
        check("wr_psel", 32'(psel_seen), 32'h8);
        check("wr_paddr", paddr_seen, 32'h0300_0010);
        check("wr_pwdata", pwdata_seen, 32'hA5A5_0001);
        check("wr_pwrite", 32'(pwrite_seen), 32'd1);
        check("wr_hresp", 32'(HRESP), 32'd0);
        check("wr_psel_end", 32'(PSEL), 32'd0);
        tick();

        // Read with two PREADY-low cycles.
        xfer(1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 2, 1'b0, 32'h1234_5678);
        check("rd_acc", 32'(acccyc), 32'd3);
        check("rd_low", 32'(lowcyc), 32'd5);
        check("rd_psel", 32'(psel_seen), 32'h1);
        check("rd_hrdata", HRDATA, 32'h1234_5678);
        check("rd_hresp", 32'(HRESP), 32'd0);
        check("rd_pwdata_held", PWDATA, 32'hA5A5_0001);
        tick();

        // Slot 5 with four slaves: no APB activity, two-cycle error.
        xfer(1'b0, 32'h0500_0000, 32'h0, 0, 1'b0, 32'h0);
        check("bad_psel", 32'(psel_seen), 32'd0);
        check("bad_low", 32'(lowcyc), 32'd2);
        check("bad_err1_resp", 32'(resp_low_last), 32'd1);
        check("bad_err2_resp", 32'(HRESP), 32'd1);
        tick();
        check("bad_after_resp", 32'(HRESP), 32'd0);
        check("bad_after_rdy", 32'(HREADYOUT), 32'd1);

        // PSLVERR on a read leaves HRDATA alone.
        xfer(1'b0, 32'h0100_0008, 32'h0, 0, 1'b1, 32'hDEAD_BEEF);
        check("slverr_psel", 32'(psel_seen), 32'h2);
        check("slverr_low", 32'(lowcyc), 32'd4);
        check("slverr_err1", 32'(resp_low_last), 32'd1);
        check("slverr_err2", 32'(HRESP), 32'd1);
        check("slverr_hrdata", HRDATA, 32'h1234_5678);
        tick();

        // PREADY held low: eight ACCESS cycles then error response.
        xfer(1'b0, 32'h0200_0000, 32'h0, 1000, 1'b0, 32'h5555_AAAA);
        check("to_acc", 32'(acccyc), 32'd8);
        check("to_low", 32'(lowcyc), 32'd11);
        check("to_psel", 32'(psel_seen), 32'h4);
        check("to_hresp", 32'(HRESP), 32'd1);
        check("to_penable_end", 32'(PENABLE), 32'd0);
        check("to_hrdata", HRDATA, 32'h1234_5678);
        tick();

        // Back-to-back writes: second presented in the completion cycle of the first.
        xfer(1'b1, 32'h0000_0020, 32'h1111_1111, 0, 1'b0, 32'h0);
        check("b2b1_pwdata", pwdata_seen, 32'h1111_1111);
        xfer(1'b1, 32'h0200_0030, 32'h2222_2222, 1, 1'b0, 32'h0);
        check("b2b2_psel", 32'(psel_seen), 32'h4);
        check("b2b2_paddr", paddr_seen, 32'h0200_0030);
        check("b2b2_pwdata", pwdata_seen, 32'h2222_2222);
        check("b2b2_acc", 32'(acccyc), 32'd2);
        check("b2b2_hresp", 32'(HRESP), 32'd0);

        // Error, then a read accepted during ERR2.
        xfer(1'b0, 32'h0700_0000, 32'h0, 0, 1'b0, 32'h0);
        check("err_then_resp", 32'(HRESP), 32'd1);
        xfer(1'b0, 32'h0300_0000, 32'h0, 0, 1'b0, 32'hCAFE_F00D);
        check("err2rd_psel", 32'(psel_seen), 32'h8);
        check("err2rd_hrdata", HRDATA, 32'hCAFE_F00D);
        check("err2rd_hresp", 32'(HRESP), 32'd0);
        check("err2rd_low", 32'(lowcyc), 32'd3);

        // Reset pulsed in the middle of ACCESS.
        HSEL = 1'b1; HADDR = 32'h0100_0040; HWRITE = 1'b1; HTRANS = 2'b10; HWDATA = 32'h7777_7777;
        PREADY = 1'b0;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        tick();
        tick();
        check("rst_mid_in_access", 32'(PENABLE), 32'd1);
        #2 HRESET = 1'b1;
        #1;
        check("rstm_psel", 32'(PSEL), 32'd0);
        check("rstm_penable", 32'(PENABLE), 32'd0);
        check("rstm_hreadyout", 32'(HREADYOUT), 32'd1);
        check("rstm_hresp", 32'(HRESP), 32'd0);
        check("rstm_paddr", PADDR, 32'd0);
        check("rstm_pwdata", PWDATA, 32'd0);
        check("rstm_hrdata", HRDATA, 32'd0);
        check("rstm_pwrite", 32'(PWRITE), 32'd0);
        tick();
        HRESET = 1'b0;
        tick();
        check("post_rst_hresp", 32'(HRESP), 32'd0);
        check("post_rst_rdy", 32'(HREADYOUT), 32'd1);
        xfer(1'b0, 32'h0100_0000, 32'h0, 0, 1'b0, 32'h0BAD_F00D);
        check("post_rst_hrdata", HRDATA, 32'h0BAD_F00D);
        check("post_rst_low", 32'(lowcyc), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ahbl_apb_bridge_gen2.md
AHBL_APB_BRIDGE_GEN2 -- requirements
Module: ahbl_apb_bridge_gen2

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 16, number of APB select lines (legal 1..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, HADDR/PADDR width.
REQ-003 SHALL have parameter SEL_LSB, default 24, LSB of the 4-bit slot field HADDR[SEL_LSB+3:SEL_LSB].
REQ-004 SHALL have parameter TIMEOUT, default 256, maximum ACCESS cycles with PREADY low (0 = no timeout).
REQ-005 SHALL have one clock and an asynchronous, active-high reset; the clock port is named HCLK and the reset port is named HRESET.
REQ-006 SHALL have port HCLK  in  1  clock; all logic rising-edge.
REQ-007 SHALL have port HRESET  in  1  asynchronous active-high reset.
REQ-008 SHALL have AHB-Lite slave ports: HSEL in 1; HADDR in ADDR_WIDTH; HWRITE in 1; HTRANS in 2; HWDATA in 32; HREADYIN in 1; HREADYOUT out 1; HRDATA out 32; HRESP out 1 (1 = ERROR).
REQ-009 SHALL have APB master ports: PSEL out NUM_SLAVES (one-hot); PADDR out ADDR_WIDTH; PWRITE out 1; PENABLE out 1; PWDATA out 32; PRDATA in 32; PREADY in 1; PSLVERR in 1.

Function
REQ-010 SHALL implement the states IDLE, LATCH, SETUP, ACCESS, ERR1 and ERR2.
REQ-011 SHALL accept a transfer only in IDLE or ERR2, when HSEL=1, HREADYIN=1 and HTRANS[1]=1; it SHALL then register HADDR to PADDR and HWRITE to PWRITE, and move to LATCH.
REQ-012 SHALL otherwise treat HTRANS IDLE/BUSY, HSEL=0 or HREADYIN=0 as no transfer: ERR2 goes to IDLE, and IDLE stays in IDLE.
REQ-013 SHALL, in LATCH, drive HREADYOUT=0 and register HWDATA to PWDATA for writes (PWDATA unchanged for reads).
REQ-014 SHALL, in LATCH, go to ERR1 without any APB activity when the slot field is >= NUM_SLAVES, and otherwise go to SETUP.
REQ-015 SHALL, in SETUP, assert PSEL[slot]=1 with PENABLE=0, then go unconditionally to ACCESS.
REQ-016 SHALL, in ACCESS, hold PSEL, assert PENABLE=1, and hold PADDR, PWRITE and PWDATA stable.
REQ-017 SHALL, in ACCESS with PREADY=1 and PSLVERR=0, register PRDATA to HRDATA (reads only), drop PSEL/PENABLE, and go to IDLE with HREADYOUT=1 and HRESP=0.
REQ-018 SHALL, in ACCESS with PREADY=1 and PSLVERR=1, drop PSEL/PENABLE and go to ERR1; HRDATA SHALL be unchanged.
REQ-019 SHALL count consecutive ACCESS cycles with PREADY=0 in a wait counter that clears on entry to SETUP; when TIMEOUT!=0 and the count reaches TIMEOUT, it SHALL drop PSEL/PENABLE and go to ERR1.
REQ-020 SHALL size the wait counter as clog2(TIMEOUT+1) bits with saturation; it SHALL never wrap.
REQ-021 SHALL drive HREADYOUT=0 and HRESP=1 in ERR1, then go to ERR2.
REQ-022 SHALL drive HREADYOUT=1 and HRESP=1 in ERR2, completing the two-cycle AHB error response.
REQ-023 SHALL drive HREADYOUT=0 in LATCH, SETUP, ACCESS and ERR1, and HREADYOUT=1 in IDLE and ERR2.
REQ-024 SHALL drive HRESP=1 only in ERR1 and ERR2.
REQ-025 SHALL register all outputs (no combinational path from an input to an output).
REQ-026 SHALL hold PADDR, PWRITE, PWDATA and HRDATA at their last values when idle.
REQ-027 SHALL have at most one PSEL bit set at any time, and none outside SETUP/ACCESS.
REQ-028 SHALL give a zero-wait transfer a 4-cycle data phase: LATCH, SETUP, ACCESS, then completion in IDLE; each PREADY-low cycle adds one cycle.
REQ-029 SHALL, on a PREADY=1 edge coinciding with the timeout count, give completion priority over timeout.

Reset
REQ-030 SHALL, while HRESET=1, force state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, HRDATA=0, HRESP=0, HREADYOUT=1, and the wait counter to 0, asynchronously.
REQ-031 SHALL, on reset mid-transfer, abandon the transfer with no completion and no error response.
REQ-032 SHALL accept a transfer on the first HCLK edge after HRESET deasserts.

Verification
REQ-033 Write 0xA5A5_0001 to HADDR 0x0300_0010 (slot 3), PREADY=1 -> PSEL=0x0008 for SETUP+ACCESS, PADDR=0x0300_0010, PWDATA=0xA5A5_0001, HREADYOUT low 3 cycles, HRESP=0.
REQ-034 Read HADDR 0x0000_0004, PRDATA=0x1234_5678, PREADY low 2 cycles -> ACCESS lasts 3 cycles, HRDATA=0x1234_5678 when HREADYOUT returns to 1.
REQ-035 NUM_SLAVES=4, access HADDR 0x0500_0000 -> PSEL stays 0; ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1).
REQ-036 PSLVERR=1 with PREADY=1 on a read -> two-cycle error response, HRDATA unchanged; TIMEOUT=8 with PREADY held 0 -> PSEL/PENABLE drop after 8 ACCESS cycles, then error response.
REQ-037 Back-to-back transfers (write presented in the completion cycle of the previous write, and a new read in ERR2) plus HRESET pulsed during ACCESS -> both back-to-back transfers run correctly; on reset all outputs take REQ-030 values immediately.
